// File: rtl/bidir_buffer_arbiter.sv
// bidir_buffer_arbiter
//   Direction arbiter for an 8-bit bidirectional buffer. It shares the buffer
//   between an A-side requester (drives A->B) and a B-side requester (drives
//   B->A). It inserts TURN_CYCLES dead cycles with CE low on every direction
//   change, and alternates ownership when both sides request at once.
//
//   Optional feature macro: BURST_LIMIT_EN
//     When defined, a grant held under contention is forcibly handed over
//     after MAX_BURST grant cycles. When undefined, no burst counter is built
//     and MAX_BURST is ignored.
//
//   Parameters
//     TURN_CYCLES  dead cycles on a direction change (1..15)
//     MAX_BURST    grant cycles before forced hand-over (1..255)
//   Ports
//     CLK    rising-edge clock
//     RST    asynchronous reset, active high
//     REQ_A  A-side request (upward, SR=1)
//     REQ_B  B-side request (downward, SR=0)
//     GNT_A  A-side owns the buffer
//     GNT_B  B-side owns the buffer
//     SR     buffer direction, 1 = A->B
//     CE     buffer enable
//     BUSY   arbiter not idle
module bidir_buffer_arbiter #(
    parameter int TURN_CYCLES = 2,
    parameter int MAX_BURST   = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic REQ_A,
    input  logic REQ_B,
    output logic GNT_A,
    output logic GNT_B,
    output logic SR,
    output logic CE,
    output logic BUSY
);

    typedef enum logic [1:0] {IDLE, TURN, GRANT_A, GRANT_B} state_t;

    localparam logic [3:0] TLAST = 4'(TURN_CYCLES - 1);

    state_t     state;
    logic       last_a;    // last owner was A (reset: B)
    logic       pend_a;    // side to be granted when TURN completes
    logic [3:0] turn_cnt;

    // IDLE pick: A wins when it requests alone, or on a tie when B owned last.
    logic pick_a;
    assign pick_a = REQ_A & (~REQ_B | ~last_a);

    // In GRANT, own/other request seen from the current owner.
    logic own_req, oth_req, burst_hit;
    assign own_req = GNT_A ? REQ_A : REQ_B;
    assign oth_req = GNT_A ? REQ_B : REQ_A;

`ifdef BURST_LIMIT_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0] burst_cnt;
    // The edge that ends the MAX_BURST-th grant cycle is the hand-over edge;
    // once saturated, a late-arriving other request also triggers it.
    assign burst_hit = (burst_cnt >= BW'(MAX_BURST - 1));
`else
    assign burst_hit = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            SR       <= 1'b0;
            CE       <= 1'b0;
            GNT_A    <= 1'b0;
            GNT_B    <= 1'b0;
            BUSY     <= 1'b0;
            last_a   <= 1'b0;
            pend_a   <= 1'b0;
            turn_cnt <= '0;
`ifdef BURST_LIMIT_EN
            burst_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (REQ_A || REQ_B) begin
                        BUSY <= 1'b1;
                        if (pick_a == SR) begin
                            state  <= pick_a ? GRANT_A : GRANT_B;
                            GNT_A  <= pick_a;
                            GNT_B  <= ~pick_a;
                            CE     <= 1'b1;
                            last_a <= pick_a;
`ifdef BURST_LIMIT_EN
                            burst_cnt <= '0;
`endif
                        end else begin
                            state    <= TURN;
                            SR       <= pick_a;
                            pend_a   <= pick_a;
                            turn_cnt <= '0;
                        end
                    end
                end
                TURN: begin
                    // Completes even if the pending requester has dropped.
                    if (turn_cnt == TLAST) begin
                        state  <= pend_a ? GRANT_A : GRANT_B;
                        GNT_A  <= pend_a;
                        GNT_B  <= ~pend_a;
                        CE     <= 1'b1;
                        last_a <= pend_a;
`ifdef BURST_LIMIT_EN
                        burst_cnt <= '0;
`endif
                    end else begin
                        turn_cnt <= turn_cnt + 4'd1;
                    end
                end
                GRANT_A, GRANT_B: begin
                    if (!own_req || (burst_hit && oth_req)) begin
                        GNT_A <= 1'b0;
                        GNT_B <= 1'b0;
                        CE    <= 1'b0;
                        if (oth_req) begin
                            state    <= TURN;
                            SR       <= ~GNT_A;
                            pend_a   <= ~GNT_A;
                            turn_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end
                    end
`ifdef BURST_LIMIT_EN
                    else if (burst_cnt != BW'(MAX_BURST)) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bidir_buffer_arbiter.sv
// Directed bench for bidir_buffer_arbiter (TURN_CYCLES=2, MAX_BURST=8).
// Outputs are sampled on the falling edge as {GNT_A,GNT_B,SR,CE,BUSY}.
module tb_bidir_buffer_arbiter;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic REQ_A = 1'b0;
    logic REQ_B = 1'b0;
    logic GNT_A, GNT_B, SR, CE, BUSY;

    int checks = 0;
    int errors = 0;

    bidir_buffer_arbiter #(.TURN_CYCLES(2), .MAX_BURST(8)) dut (
        .CLK(CLK), .RST(RST), .REQ_A(REQ_A), .REQ_B(REQ_B),
        .GNT_A(GNT_A), .GNT_B(GNT_B), .SR(SR), .CE(CE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Bit order: GNT_A GNT_B SR CE BUSY
    localparam logic [4:0] O_RST   = 5'b00000;
    localparam logic [4:0] O_TURNA = 5'b00101;
    localparam logic [4:0] O_TURNB = 5'b00001;
    localparam logic [4:0] O_GA    = 5'b10111;
    localparam logic [4:0] O_GB    = 5'b01011;
    localparam logic [4:0] O_IDLEA = 5'b00100;
    localparam logic [4:0] O_IDLEB = 5'b00000;

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (GNT_A GNT_B SR CE BUSY)", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {GNT_A, GNT_B, SR, CE, BUSY};
    endfunction

    // One rising edge, then settle to the following falling edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ_A = 1'b0;
        REQ_B = 1'b0;
        step(1);
        RST = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("reset", outs(), O_RST);

        // Cold A request: SR flips at edge 1, grant at edge 3.
        REQ_A = 1'b1;
        step(1); chk("cold_a_e1", outs(), O_TURNA);
        step(1); chk("cold_a_e2", outs(), O_TURNA);
        step(1); chk("cold_a_e3", outs(), O_GA);

        // Release, then same-direction regrant with no turn.
        REQ_A = 1'b0;
        step(1); chk("rel_a", outs(), O_IDLEA);
        REQ_A = 1'b1;
        step(1); chk("regrant_a", outs(), O_GA);

        // Async reset mid-grant: outputs clear before the next edge.
        #2 RST = 1'b1;
        REQ_A = 1'b0;
        #1 chk("async_rst", outs(), O_RST);
        @(negedge CLK);
        RST = 1'b0;

        // Tie after reset: A wins, then hand-over to B.
        REQ_A = 1'b1; REQ_B = 1'b1;
        step(1); chk("tie_e1", outs(), O_TURNA);
        step(2); chk("tie_e3", outs(), O_GA);
        step(3); chk("tie_hold", outs(), O_GA);
        REQ_A = 1'b0;
        step(1); chk("tie_ho_m", outs(), O_TURNB);
        step(1); chk("tie_ho_m1", outs(), O_TURNB);
        step(1); chk("tie_ho_m2", outs(), O_GB);

        // B holds under contention from A.
        REQ_A = 1'b1;
`ifdef BURST_LIMIT_EN
        step(7); chk("burst_7", outs(), O_GB);
        step(1); chk("burst_8", outs(), O_TURNA);
        step(1); chk("burst_t2", outs(), O_TURNA);
        step(1); chk("burst_ga", outs(), O_GA);
`else
        step(12); chk("noburst_hold", outs(), O_GB);
        step(12); chk("noburst_hold2", outs(), O_GB);
`endif

        // Turn cancel: get to IDLE with SR=1, pulse REQ_B for one cycle.
        do_reset();
        REQ_A = 1'b1;
        step(3); chk("tc_ga", outs(), O_GA);
        REQ_A = 1'b0;
        step(1); chk("tc_idle", outs(), O_IDLEA);
        REQ_B = 1'b1;
        step(1); chk("tc_turn1", outs(), O_TURNB);
        REQ_B = 1'b0;
        step(1); chk("tc_turn2", outs(), O_TURNB);
        step(1); chk("tc_gb", outs(), O_GB);
        step(1); chk("tc_idle_b", outs(), O_IDLEB);
        step(2); chk("tc_stay", outs(), O_IDLEB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
